// File: rtl/tri_job_sched.sv
// tri_job_sched: round-robin front end that shares one triangle rasterizer
// among NREQ requesters. It grants one job at a time, feeds its three vertices
// to the engine over nt/xi/yi, forwards emitted points tagged with the owner ID,
// and reports done plus a saturating point count.
// Optional: define TRI_WDOG_EN to add the err output and a WAIT-state watchdog
// that forces completion after WDOG_CYCLES cycles.

module tri_job_sched #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*18-1:0]   vtx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [6:0]           pt_cnt,
`ifdef TRI_WDOG_EN
  output logic                 err,
`endif
  output logic                 eng_nt,
  output logic [2:0]           eng_xi,
  output logic [2:0]           eng_yi,
  input  logic                 eng_busy,
  input  logic                 eng_po,
  input  logic [2:0]           eng_xo,
  input  logic [2:0]           eng_yo,
  output logic                 pt_valid,
  output logic [2:0]           pt_x,
  output logic [2:0]           pt_y,
  output logic [IDW-1:0]       pt_id
);

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || WDOG_CYCLES < 1) begin : g_param_err
    $error("tri_job_sched: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD1, S_LOAD2, S_LOAD3, S_WAIT_HI, S_WAIT_LO, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [17:0]     vtx_q, vtx_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            seen_q, seen_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [6:0]      pt_cnt_q, pt_cnt_d;
  logic            eng_nt_q, eng_nt_d;
  logic [2:0]      eng_xi_q, eng_xi_d, eng_yi_q, eng_yi_d;
  logic            pt_valid_q, pt_valid_d;
  logic [2:0]      pt_x_q, pt_x_d, pt_y_q, pt_y_d;
  logic [IDW-1:0]  pt_id_q, pt_id_d;
`ifdef TRI_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0]  wd_q, wd_d;
  logic            err_q, err_d;
`endif

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [17:0]     win_vtx;
  logic            grant_go;
  logic            fwd_en;

  // Rotating priority: lowest requester above ptr wins, else wrap to lowest overall.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_vtx   = '0;
    for (int r = NREQ-1; r >= 0; r--) begin
      if (req[r]) begin
        win_found = 1'b1;
        win_id    = IDW'(r);
        win_vtx   = vtx[r*18 +: 18];
      end
    end
    for (int r = NREQ-1; r >= 0; r--) begin
      if (req[r] && (IDW'(r) > ptr_q)) begin
        win_id  = IDW'(r);
        win_vtx = vtx[r*18 +: 18];
      end
    end
  end

  // Grant is combinational so the requester sees it in the cycle its vertices are taken.
  always_comb begin
    grant_go = (state_q == S_IDLE) && win_found && !eng_busy && !reset;
    gnt      = '0;
    if (grant_go) begin
      for (int r = 0; r < NREQ; r++) gnt[r] = (IDW'(r) == win_id);
    end
  end

  // Next-state, point forwarding and registered output values.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_id_d   = cur_id_q;
    vtx_d      = vtx_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    done_d     = '0;
    pt_cnt_d   = pt_cnt_q;
    eng_nt_d   = 1'b0;
    eng_xi_d   = '0;
    eng_yi_d   = '0;
    pt_valid_d = 1'b0;
    pt_x_d     = '0;
    pt_y_d     = '0;
    pt_id_d    = '0;
`ifdef TRI_WDOG_EN
    wd_d       = '0;
    err_d      = 1'b0;
`endif

    fwd_en = (state_q == S_LOAD1) || (state_q == S_LOAD2) || (state_q == S_LOAD3) ||
             (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
    if (fwd_en && eng_po) begin
      pt_valid_d = 1'b1;
      pt_x_d     = eng_xo;
      pt_y_d     = eng_yo;
      pt_id_d    = cur_id_q;
      if (cnt_q != 7'd64) cnt_d = cnt_q + 7'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (grant_go) begin
          state_d  = S_LOAD1;
          vtx_d    = win_vtx;
          cur_id_d = win_id;
          cnt_d    = '0;
          seen_d   = 1'b0;
        end
      end
      S_LOAD1: begin
        state_d = S_LOAD2;
        seen_d  = seen_q | eng_busy;
      end
      S_LOAD2: begin
        state_d = S_LOAD3;
        seen_d  = seen_q | eng_busy;
      end
      S_LOAD3: begin
        state_d = S_WAIT_HI;
        seen_d  = seen_q | eng_busy;
      end
      // A busy pulse already seen during loading counts as the rising edge.
      S_WAIT_HI: if (seen_q || eng_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: if (!eng_busy) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = cur_id_q;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef TRI_WDOG_EN
    if ((state_q == S_WAIT_HI) || (state_q == S_WAIT_LO)) begin
      wd_d = wd_q + WDW'(1);
      if ((state_d != S_DONE) && (wd_q == WDW'(WDOG_CYCLES - 1))) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end
    end
`endif

    // Engine-side and completion outputs follow the state being entered.
    case (state_d)
      S_LOAD1: begin
        eng_nt_d = 1'b1;
        eng_xi_d = vtx_d[17:15];
        eng_yi_d = vtx_d[14:12];
      end
      S_LOAD2: begin
        eng_xi_d = vtx_d[11:9];
        eng_yi_d = vtx_d[8:6];
      end
      S_LOAD3: begin
        eng_xi_d = vtx_d[5:3];
        eng_yi_d = vtx_d[2:0];
      end
      S_DONE: begin
        for (int r = 0; r < NREQ; r++) done_d[r] = (IDW'(r) == cur_id_q);
        pt_cnt_d = cnt_d;
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any job and clears every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      cur_id_q   <= '0;
      vtx_q      <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      done_q     <= '0;
      pt_cnt_q   <= '0;
      eng_nt_q   <= 1'b0;
      eng_xi_q   <= '0;
      eng_yi_q   <= '0;
      pt_valid_q <= 1'b0;
      pt_x_q     <= '0;
      pt_y_q     <= '0;
      pt_id_q    <= '0;
`ifdef TRI_WDOG_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_id_q   <= cur_id_d;
      vtx_q      <= vtx_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      done_q     <= done_d;
      pt_cnt_q   <= pt_cnt_d;
      eng_nt_q   <= eng_nt_d;
      eng_xi_q   <= eng_xi_d;
      eng_yi_q   <= eng_yi_d;
      pt_valid_q <= pt_valid_d;
      pt_x_q     <= pt_x_d;
      pt_y_q     <= pt_y_d;
      pt_id_q    <= pt_id_d;
`ifdef TRI_WDOG_EN
      wd_q       <= wd_d;
      err_q      <= err_d;
`endif
    end
  end

  assign done     = done_q;
  assign pt_cnt   = pt_cnt_q;
  assign eng_nt   = eng_nt_q;
  assign eng_xi   = eng_xi_q;
  assign eng_yi   = eng_yi_q;
  assign pt_valid = pt_valid_q;
  assign pt_x     = pt_x_q;
  assign pt_y     = pt_y_q;
  assign pt_id    = pt_id_q;
`ifdef TRI_WDOG_EN
  assign err      = err_q;
`endif

endmodule

// File: tb/tb_tri_job_sched.sv
// tb_tri_job_sched: directed bench for tri_job_sched with a behavioural engine.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.

module tb_tri_job_sched;
  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [71:0] vtx;
  logic [3:0]  gnt, done;
  logic [6:0]  pt_cnt;
  logic        eng_nt;
  logic [2:0]  eng_xi, eng_yi;
  logic        eng_busy, eng_po;
  logic [2:0]  eng_xo, eng_yo;
  logic        pt_valid;
  logic [2:0]  pt_x, pt_y;
  logic [1:0]  pt_id;
`ifdef TRI_WDOG_EN
  logic        err;
`endif

  tri_job_sched #(.NREQ(4), .IDW(2), .WDOG_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .req(req), .vtx(vtx), .gnt(gnt), .done(done),
    .pt_cnt(pt_cnt),
`ifdef TRI_WDOG_EN
    .err(err),
`endif
    .eng_nt(eng_nt), .eng_xi(eng_xi), .eng_yi(eng_yi), .eng_busy(eng_busy),
    .eng_po(eng_po), .eng_xo(eng_xo), .eng_yo(eng_yo), .pt_valid(pt_valid),
    .pt_x(pt_x), .pt_y(pt_y), .pt_id(pt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Engine model controls
  int   e_npts = 0;
  logic e_stuck = 1'b0;
  logic e_force_busy = 1'b0;
  int   stray_req = 0;
  int   stray_done = 0;
  logic stray_now = 1'b0;
  logic e_act = 1'b0;
  int   e_cnt = 0;
  logic [1:0] exp_id = 2'd0;
  int   pv_total = 0;

  // Engine: after nt, one busy-only cycle, then e_npts point cycles, then busy drops.
  initial begin
    eng_busy = 1'b0; eng_po = 1'b0; eng_xo = '0; eng_yo = '0;
    forever begin
      @(posedge clk); #1;
      stray_now = 1'b0;
      if (reset) begin
        e_act = 1'b0; eng_busy = 1'b0; eng_po = 1'b0; eng_xo = '0; eng_yo = '0;
      end else if (e_act) begin
        eng_po = 1'b0;
        if (e_cnt == 0) eng_busy = 1'b1;
        else if (e_cnt <= e_npts) begin
          eng_busy = 1'b1; eng_po = 1'b1;
          eng_xo = 3'(e_cnt); eng_yo = 3'(e_cnt * 5);
        end else if (e_stuck) eng_busy = 1'b1;
        else begin eng_busy = 1'b0; e_act = 1'b0; end
        e_cnt++;
      end else begin
        eng_busy = e_force_busy;
        eng_po = 1'b0;
        if (stray_req != stray_done) begin
          stray_done = stray_req; eng_po = 1'b1; stray_now = 1'b1;
          eng_xo = 3'd5; eng_yo = 3'd2;
        end
        if (eng_nt) begin e_act = 1'b1; e_cnt = 0; end
      end
    end
  end

  // Point monitor: every engine point must reappear one cycle later with the owner ID.
  logic       prev_po = 1'b0;
  logic [2:0] prev_x = '0, prev_y = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) prev_po = 1'b0;
      else begin
        if (pt_valid || prev_po) begin
          chk("pt_valid", 32'(pt_valid), 32'(prev_po));
          if (prev_po) begin
            chk("pt_x", 32'(pt_x), 32'(prev_x));
            chk("pt_y", 32'(pt_y), 32'(prev_y));
            chk("pt_id", 32'(pt_id), 32'(exp_id));
          end
        end
        if (pt_valid) pv_total++;
        prev_po = eng_po && !stray_now;
        prev_x = eng_xo; prev_y = eng_yo;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input int limit, output logic [3:0] g);
    g = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (gnt != 0) begin g = gnt; return; end
      nxt();
    end
    chk("gnt_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_done(input int limit, output logic [3:0] d, output int cyc);
    d = '0; cyc = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done != 0) begin
        d = done; cyc = i;
        chk("gnt_in_done", 32'(gnt), 32'(0));
        return;
      end
      nxt();
    end
    chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0;
    nxt(); nxt();
    reset = 1'b0;
  endtask

  logic [3:0] g, d;
  int cyc, base, any;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; req = 4'b0001; vtx = '0;
    vtx[0*18 +: 18] = {3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7};
    vtx[1*18 +: 18] = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    vtx[2*18 +: 18] = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    vtx[3*18 +: 18] = {3'd7, 3'd7, 3'd1, 3'd1, 3'd4, 3'd0};

    // Reset state, with a request already pending
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_nt", 32'(eng_nt), 32'(0));
    chk("rst_pv", 32'(pt_valid), 32'(0));
    chk("rst_cnt", 32'(pt_cnt), 32'(0));
    nxt();
    reset = 1'b0;

    // Single 36-point job from requester 0
    e_npts = 36; base = pv_total;
    wait_gnt(5, g);
    chk("t1_gnt", 32'(g), 32'(4'b0001));
    exp_id = 2'd0;
    nxt(); req = '0; @(negedge clk);
    chk("t1_gnt_pulse", 32'(gnt), 32'(0));
    chk("t1_l1", 32'({eng_nt, eng_xi, eng_yi}), 32'({1'b1, 3'd0, 3'd0}));
    nxt(); @(negedge clk);
    chk("t1_l2", 32'({eng_nt, eng_xi, eng_yi}), 32'({1'b0, 3'd7, 3'd0}));
    nxt(); @(negedge clk);
    chk("t1_l3", 32'({eng_nt, eng_xi, eng_yi}), 32'({1'b0, 3'd0, 3'd7}));
    nxt(); @(negedge clk);
    chk("t1_after", 32'({eng_nt, eng_xi, eng_yi}), 32'(0));
    nxt();
    wait_done(100, d, cyc);
    chk("t1_done", 32'(d), 32'(4'b0001));
    chk("t1_cnt", 32'(pt_cnt), 32'(36));
`ifdef TRI_WDOG_EN
    chk("t1_err", 32'(err), 32'(0));
`endif
    nxt(); @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'(0));
    chk("t1_cnt_held", 32'(pt_cnt), 32'(36));
    chk("t1_pv_total", 32'(pv_total - base), 32'(36));

    // Engine point while idle is ignored
    nxt(); stray_req++;
    any = 0;
    for (int i = 0; i < 3; i++) begin
      nxt(); @(negedge clk);
      if (pt_valid) any = 1;
    end
    chk("stray_pv", 32'(any), 32'(0));
    chk("stray_cnt", 32'(pt_cnt), 32'(36));

    // All requesting continuously: strict rotation
    do_reset();
    e_npts = 3; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(20, g);
      chk("rr_gnt", 32'(g), 32'(4'b0001 << order[i]));
      exp_id = 2'(order[i]);
      nxt();
      wait_done(50, d, cyc);
      chk("rr_done", 32'(d), 32'(g));
      chk("rr_cnt", 32'(pt_cnt), 32'(3));
      nxt();
    end
    req = '0;

    // Served 2, then 0 and 2 request: 0 first (search 3,0), then 2
    do_reset();
    e_npts = 2; req = 4'b0100;
    wait_gnt(5, g);
    chk("fair_g2", 32'(g), 32'(4'b0100));
    exp_id = 2'd2;
    nxt(); req = '0;
    wait_done(50, d, cyc);
    nxt(); req = 4'b0101;
    wait_gnt(5, g);
    chk("fair_g0", 32'(g), 32'(4'b0001));
    exp_id = 2'd0;
    nxt();
    wait_done(50, d, cyc);
    nxt();
    wait_gnt(5, g);
    chk("fair_g2b", 32'(g), 32'(4'b0100));
    exp_id = 2'd2;
    nxt(); req = '0;
    wait_done(50, d, cyc);
    chk("fair_done", 32'(d), 32'(4'b0100));

    // Engine busy blocks arbitration
    do_reset();
    e_force_busy = 1'b1; e_npts = 3;
    nxt(); nxt();
    req = 4'b0010; any = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (gnt != 0) any = 1;
      nxt();
    end
    chk("busy_nogrant", 32'(any), 32'(0));
    e_force_busy = 1'b0;
    wait_gnt(2, g);
    chk("busy_gnt", 32'(g), 32'(4'b0010));
    exp_id = 2'd1;
    nxt(); req = '0;
    wait_done(50, d, cyc);
    chk("busy_done", 32'(d), 32'(4'b0010));

    // Reset in WAIT_LO while points flow
    do_reset();
    e_npts = 20; req = 4'b0001;
    wait_gnt(5, g);
    exp_id = 2'd0;
    nxt(); req = '0;
    repeat (6) nxt();
    reset = 1'b1; req = 4'b1000;
    #1;
    chk("mid_rst_pv", 32'(pt_valid), 32'(0));
    chk("mid_rst_out", 32'({gnt, done, eng_nt, eng_xi, eng_yi}), 32'(0));
    chk("mid_rst_cnt", 32'(pt_cnt), 32'(0));
    nxt(); nxt();
    reset = 1'b0;
    wait_gnt(3, g);
    chk("mid_rst_gnt", 32'(g), 32'(4'b1000));
    exp_id = 2'd3;
    nxt(); req = '0;
    wait_done(60, d, cyc);
    chk("mid_rst_done", 32'(d), 32'(4'b1000));
    chk("mid_rst_pts", 32'(pt_cnt), 32'(20));

    // Counter saturation at 64
    nxt();
    e_npts = 70; req = 4'b0010; base = pv_total;
    wait_gnt(5, g);
    chk("sat_gnt", 32'(g), 32'(4'b0010));
    exp_id = 2'd1;
    nxt(); req = '0;
    wait_done(150, d, cyc);
    chk("sat_cnt", 32'(pt_cnt), 32'(64));
    nxt(); @(negedge clk);
    chk("sat_pv_total", 32'(pv_total - base), 32'(70));

`ifdef TRI_WDOG_EN
    // Watchdog: busy never drops; done 20 cycles after entering WAIT_HI
    nxt();
    e_npts = 0; e_stuck = 1'b1; req = 4'b0001;
    wait_gnt(5, g);
    exp_id = 2'd0;
    nxt(); req = '0;
    wait_done(60, d, cyc);
    chk("wdog_cyc", 32'(cyc), 32'(24));
    chk("wdog_done", 32'(d), 32'(4'b0001));
    chk("wdog_err", 32'(err), 32'(1));
    chk("wdog_cnt", 32'(pt_cnt), 32'(0));
    e_stuck = 1'b0;
    nxt(); nxt(); nxt(); @(negedge clk);
    chk("wdog_err_clr", 32'(err), 32'(0));
`endif

    nxt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tri_job_sched.md
Name: tri_job_sched

Overview:
- Round-robin scheduler that shares one triangle rasterization engine between NREQ requesters.
- Each requester presents a whole triangle (three 3-bit vertices) with a request line.
- The block arbitrates, loads the winning triangle into the engine over the nt/xi/yi serial protocol, and forwards emitted points tagged with the requester ID.
- At job end it returns a done pulse and a point count. It sits between the host-side job queues and the rasterizer.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ
WDOG_CYCLES, 255, watchdog limit in cycles (used only with TRI_WDOG_EN)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester job request; level, held until gnt
vtx  input  NREQ*18  per-requester triangle, slice r = {x1,y1,x2,y2,x3,y3}, 3 bits each, x1 in MSBs
gnt  output  NREQ  one-hot, 1-cycle pulse; vertices captured this cycle
done  output  NREQ  one-hot, 1-cycle pulse at job completion
pt_cnt  output  7  points emitted by last job; valid while done pulses, held after
eng_nt  output  1  engine new-triangle strobe
eng_xi  output  3  vertex x to engine
eng_yi  output  3  vertex y to engine
eng_busy  input  1  engine busy
eng_po  input  1  engine point valid
eng_xo  input  3  engine point x
eng_yo  input  3  engine point y
pt_valid  output  1  forwarded point valid
pt_x  output  3  forwarded point x
pt_y  output  3  forwarded point y
pt_id  output  IDW  requester owning the forwarded point

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer = NREQ-1, so requester 0 has first priority.
- IDLE: if any req and eng_busy==0, go to LOAD1.
  - Winner is the first requester set, searching from ptr+1 with wrap-around.
  - Same cycle: gnt[w]=1; vtx slice latched into internal registers; cur_id=w; point counter cleared.
- LOAD1: eng_nt=1, eng_xi/yi=x1/y1.
- LOAD2: eng_nt=0, eng_xi/yi=x2/y2.
- LOAD3: eng_xi/yi=x3/y3.
- In all other states eng_nt=0 and eng_xi/yi=0.
- WAIT_HI: wait for eng_busy==1. A busy already high during LOAD2/LOAD3 counts; a flag set on any busy=1 seen since LOAD1 satisfies WAIT_HI immediately.
- WAIT_LO: wait for eng_busy==0, then go to DONE.
- DONE: done[cur_id]=1 for one cycle; pt_cnt=counter; ptr=cur_id; go to IDLE. No new grant in the DONE cycle.
- Point forwarding, from LOAD1 through WAIT_LO:
  - eng_po registered to pt_valid with 1-cycle latency; pt_x/pt_y/pt_id registered alongside.
  - Counter increments per eng_po and saturates at 64.
  - eng_po outside these states is ignored: no pt_valid, no count.
- req deasserted before gnt: no grant. req held after gnt is treated as a new job on a later arbitration.
- req changes after gnt do not affect the running job, because vertices are latched.
- Fairness: the requester just served has lowest priority at the next arbitration.
- Reset mid-job: immediate return to IDLE and all outputs 0. The engine is reset externally by the same reset.

Optional Feature:
Macro TRI_WDOG_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - A cycle counter runs in WAIT_HI/WAIT_LO.
  - Reaching WDOG_CYCLES forces DONE with err=1 for the done cycle; pt_cnt reports points so far.
  - err=0 on normal completion.
- Undefined: no err port, no counter; WAIT states wait indefinitely.

Test Plan:
- req=4'b0001, vtx0={0,0,7,0,0,7}; engine model emits 36 points then drops busy:
  - gnt=0001 one cycle;
  - eng_nt high only in the LOAD1 cycle, with xi/yi 0,0 then 7,0 then 0,7 on consecutive cycles;
  - 36 pt_valid pulses with pt_id=0, each one cycle after eng_po;
  - done=0001 with pt_cnt=36.
- req=4'b1111 held continuously, 3-point engine jobs -> grant order 0,1,2,3,0; exactly one done per grant.
- After serving requester 2, req=4'b0101 -> next gnt=0001 (searching 3,0), then gnt=0100.
- eng_busy held high at arbitration time with req=0010 -> no gnt until busy low; then gnt=0010 within 1 cycle.
- Reset asserted in WAIT_LO mid-job -> all outputs 0 immediately; after release with req=1000 -> gnt=0001 only if req0 set, else gnt=1000.
- TRI_WDOG_EN defined, WDOG_CYCLES=20, engine busy stuck high -> done pulse with err=1 exactly 20 cycles after entering WAIT_HI.
